vdp1_cmd_sequencer: RTL and testbench
=====================================

Name: vdp1_cmd_sequencer

Overview:
- Command-list walker for VDP1. On a plot trigger it reads 32-byte command tables from VRAM one 16-bit word at a time.
- It interprets CMDCTRL END/JP fields and follows CMDLINK jump, call and return chains.
- It presents each drawable command table to the draw engine over a valid/ready handshake, and maintains COPR/LOPR/CEF status for the register block.
- It sits between the VRAM arbiter (read port) and the command decoder/draw engine.

Parameters:
- CALL_DEPTH, 1, return-address stack entries (hardware-accurate value is 1).
- MAX_CMDS, 16'd16383, command-count limit per plot. Used only when the watchdog macro is defined.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE  in  1  clock enable; all state advances only when CE=1
- START  in  1  one-cycle plot trigger (from PTMR/frame-change logic)
- VRAM_A  out  18  word address [18:1]
- VRAM_RD  out  1  read request; held until VRAM_RDY
- VRAM_D  in  16  read data, valid with VRAM_RDY
- VRAM_RDY  in  1  read completion strobe
- CMD  out  256  command table, word 0 in bits [255:240]; word 15 always 0
- CMD_VALID  out  1  CMD valid for the draw engine
- CMD_READY  in  1  draw engine accepts CMD
- COPR  out  16  current table address in 8-byte units (bits [1:0]=0)
- LOPR  out  16  address of last table issued or skipped
- CEF  out  1  END reached in current plot
- BUSY  out  1  high from START until IDLE
- WDOG_OVF  out  1  watchdog overflow flag (0 when feature absent)

Behaviour:
- Reset: every output is 0. Internal state: IDLE, stack empty, word counter 0, command counter 0.
- Address rules:
  - Table address TA is 16 bits in 8-byte units. Word address = {TA, 2'b00} + word index (18-bit, wraps mod 2^18).
  - NEXT address = TA + 4 (16-bit wrap, so 0xFFFC -> 0x0000).
- FSM states: IDLE, FETCH, ISSUE, LINK, DONE.
- IDLE:
  - START -> TA=0, stack cleared, CEF=0, BUSY=1, go to FETCH with word index 0.
- FETCH:
  - Assert VRAM_RD with VRAM_A. On VRAM_RDY, capture VRAM_D into word slot i.
  - VRAM_RD deasserts for one cycle between reads; at most one read is outstanding.
  - After word 0 is captured:
    - END=1 -> CEF=1, COPR=TA, go to DONE. No further reads.
    - JP[2]=1 (skip) -> fetch word 1 only, then LOPR=TA and go to LINK.
    - Otherwise fetch words 1..14 (word 15 is never read), then go to ISSUE.
  - Read count per table: 15 for normal, 2 for skip, 1 for END.
- ISSUE:
  - CMD_VALID=1, CMD stable until CMD_READY is sampled high. The handshake completes on the CE cycle where both are high.
  - Then LOPR=TA, CMD_VALID=0, go to LINK.
  - CMD_READY while CMD_VALID=0 is ignored.
- LINK (one cycle), by JP[1:0]:
  - 00: TA = NEXT.
  - 01: TA = CMDLINK & 0xFFFC.
  - 10 (call): push NEXT, then TA = CMDLINK & 0xFFFC. If the stack is full, overwrite the top entry.
  - 11 (return): if stack not empty, pop into TA; if empty, TA = NEXT.
  - COPR=TA, then go to FETCH.
- DONE: BUSY=0, go to IDLE. CEF holds until the next START.
- START while BUSY:
  - Abort the walk, discard the in-flight read result, drop CMD_VALID, clear the stack, restart at TA=0, CEF=0.
  - Takes effect the same cycle, even mid-handshake.
- CE=0 freezes all state and outputs. A VRAM_RDY arriving with CE=0 is ignored; the arbiter holds RDY until CE.
- Simultaneous START and CMD_READY: START wins and the command is not counted as issued (LOPR unchanged).

Optional Feature:
- Macro VDP1_CMD_WATCHDOG_EN.
- Defined:
  - A 16-bit counter increments on every table reaching LINK, including skipped tables.
  - When it reaches MAX_CMDS, the walk goes to DONE: WDOG_OVF=1, CEF=1, COPR=current TA.
  - The counter and WDOG_OVF clear on START.
- Undefined: no counter; WDOG_OVF tied 0; looping lists run until the next START.

Test Plan:
- Linear list: tables at 0x0000 (JP=000) and 0x0004 (END=1); START -> one CMD issued with word 0 of table 0; 15+1 reads; CEF=1; LOPR=0x0000; COPR=0x0004.
- Jump/skip: table 0 JP=101, CMDLINK=0x0123; table 0x0120 has END -> 2 reads at word addresses 0,1; no CMD_VALID; LOPR=0x0000; next read at word address 0x00480.
- Call/return: 0 call->0x0040; 0x0040 return; 0x0004 END -> tables issued in order 0x0000, 0x0040; third fetch at TA=0x0004.
- Return with empty stack from TA=0x0010 -> next fetch at 0x0014.
- Backpressure plus restart: hold CMD_READY=0 for 20 cycles -> CMD_VALID stays high and CMD stable. Then pulse START -> CMD_VALID drops, the next read address is 0, CEF=0.
- With VDP1_CMD_WATCHDOG_EN, MAX_CMDS=3, table 0 JP=001 link=0 (self-loop) -> exactly 3 tables issued; WDOG_OVF=1; CEF=1; BUSY falls.

Source files
------------

// File: rtl/vdp1_cmd_sequencer_if.sv
// VDP1 command sequencer bus bundle: VRAM read port and the command handshake to the draw engine.
// master = sequencer side, slave = arbiter/draw-engine side.
interface vdp1_cmd_sequencer_if;
  logic [17:0]  VRAM_A;
  logic         VRAM_RD;
  logic [15:0]  VRAM_D;
  logic         VRAM_RDY;
  logic [255:0] CMD;
  logic         CMD_VALID;
  logic         CMD_READY;

  modport master (
    output VRAM_A, VRAM_RD, CMD, CMD_VALID,
    input  VRAM_D, VRAM_RDY, CMD_READY
  );

  modport slave (
    input  VRAM_A, VRAM_RD, CMD, CMD_VALID,
    output VRAM_D, VRAM_RDY, CMD_READY
  );
endinterface

// File: rtl/vdp1_cmd_sequencer.sv
// VDP1 command-list walker: fetches 32-byte tables, follows END/JP/CMDLINK, issues drawable tables.
// Optional plot watchdog enabled by defining VDP1_CMD_WATCHDOG_EN.
module vdp1_cmd_sequencer #(
  parameter int unsigned CALL_DEPTH = 1,
  parameter logic [15:0] MAX_CMDS   = 16'd16383
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        CE,
  input  logic                        START,
  vdp1_cmd_sequencer_if.master        bus,
  output logic [15:0]                 COPR,
  output logic [15:0]                 LOPR,
  output logic                        CEF,
  output logic                        BUSY,
  output logic                        WDOG_OVF
);

  localparam int unsigned SpW = $clog2(CALL_DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StLink, StDone} state_e;

  state_e         state_q;
  logic [15:0]    ta_q;
  logic [3:0]     widx_q;
  logic [15:0]    words_q [15];
  logic           rd_q;
  logic [17:0]    addr_q;
  logic           cmd_valid_q;
  logic [15:0]    copr_q;
  logic [15:0]    lopr_q;
  logic           cef_q;
  logic           busy_q;
  logic [15:0]    stack_q [CALL_DEPTH];
  logic [SpW-1:0] sp_q;

  logic [1:0]     jp_link;
  logic           jp_skip;
  logic [15:0]    next_ta;
  logic [15:0]    link_target;
  logic           stack_empty;
  logic           stack_full;
  logic [SpW-1:0] sp_top;
  logic [SpW-1:0] push_idx;
  logic           wdog_hit;
  logic [255:0]   cmd_w;

  assign jp_link     = words_q[0][13:12];
  assign jp_skip     = words_q[0][14];
  assign next_ta     = ta_q + 16'd4;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SpW'(CALL_DEPTH));
  assign sp_top      = sp_q - SpW'(1);
  // A call on a full stack overwrites the top entry instead of growing.
  assign push_idx    = stack_full ? sp_top : sp_q;

  always_comb begin
    link_target = next_ta;
    unique case (jp_link)
      2'b00:        link_target = next_ta;
      2'b01, 2'b10: link_target = words_q[1] & 16'hFFFC;
      default:      link_target = stack_empty ? next_ta : stack_q[sp_top];
    endcase
  end

`ifdef VDP1_CMD_WATCHDOG_EN
  logic [15:0] cmd_cnt_q;
  logic        wdog_q;
  assign wdog_hit = ((cmd_cnt_q + 16'd1) == MAX_CMDS);
  assign WDOG_OVF = wdog_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmd_cnt_q <= '0;
      wdog_q    <= 1'b0;
    end else if (CE) begin
      if (START) begin
        cmd_cnt_q <= '0;
        wdog_q    <= 1'b0;
      end else if (state_q == StLink) begin
        cmd_cnt_q <= cmd_cnt_q + 16'd1;
        if (wdog_hit) wdog_q <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^MAX_CMDS;
  assign wdog_hit   = 1'b0;
  assign WDOG_OVF   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      ta_q        <= '0;
      widx_q      <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      cmd_valid_q <= 1'b0;
      copr_q      <= '0;
      lopr_q      <= '0;
      cef_q       <= 1'b0;
      busy_q      <= 1'b0;
      sp_q        <= '0;
      for (int i = 0; i < 15; i++) words_q[i] <= '0;
      for (int i = 0; i < int'(CALL_DEPTH); i++) stack_q[i] <= '0;
    end else if (CE) begin
      if (START) begin
        // Restart wins over everything, including a completing handshake or read.
        state_q     <= StFetch;
        ta_q        <= '0;
        copr_q      <= '0;
        widx_q      <= '0;
        rd_q        <= 1'b0;
        cmd_valid_q <= 1'b0;
        sp_q        <= '0;
        cef_q       <= 1'b0;
        busy_q      <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: ;
          StFetch: begin
            if (!rd_q) begin
              rd_q   <= 1'b1;
              addr_q <= {ta_q, 2'b00} + 18'(widx_q);
            end else if (bus.VRAM_RDY) begin
              rd_q            <= 1'b0;
              words_q[widx_q] <= bus.VRAM_D;
              if (widx_q == 4'd0 && bus.VRAM_D[15]) begin
                cef_q   <= 1'b1;
                copr_q  <= ta_q;
                state_q <= StDone;
              end else if (widx_q == 4'd1 && jp_skip) begin
                lopr_q  <= ta_q;
                state_q <= StLink;
              end else if (widx_q == 4'd14) begin
                cmd_valid_q <= 1'b1;
                state_q     <= StIssue;
              end else begin
                widx_q <= widx_q + 4'd1;
              end
            end
          end
          StIssue: begin
            if (bus.CMD_READY) begin
              lopr_q      <= ta_q;
              cmd_valid_q <= 1'b0;
              state_q     <= StLink;
            end
          end
          StLink: begin
            if (jp_link == 2'b10) begin
              stack_q[push_idx] <= next_ta;
              if (!stack_full) sp_q <= sp_q + SpW'(1);
            end else if (jp_link == 2'b11 && !stack_empty) begin
              sp_q <= sp_top;
            end
            if (wdog_hit) begin
              cef_q   <= 1'b1;
              copr_q  <= ta_q;
              state_q <= StDone;
            end else begin
              ta_q    <= link_target;
              copr_q  <= link_target;
              widx_q  <= '0;
              state_q <= StFetch;
            end
          end
          StDone: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    cmd_w = '0;
    for (int i = 0; i < 15; i++) cmd_w[255 - 16*i -: 16] = words_q[i];
  end

  assign bus.VRAM_A    = addr_q;
  assign bus.VRAM_RD   = rd_q;
  assign bus.CMD       = cmd_w;
  assign bus.CMD_VALID = cmd_valid_q;
  assign COPR          = copr_q;
  assign LOPR          = lopr_q;
  assign CEF           = cef_q;
  assign BUSY          = busy_q;

endmodule

// File: tb/tb_vdp1_cmd_sequencer.sv
// Scoreboard bench for vdp1_cmd_sequencer: expected read addresses and issued tables are queued by
// the stimulus and popped by monitors on each read request / command handshake.
module tb_vdp1_cmd_sequencer;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE    = 1'b1;
  logic        START = 1'b0;
  logic [15:0] COPR;
  logic [15:0] LOPR;
  logic        CEF;
  logic        BUSY;
  logic        WDOG_OVF;

  vdp1_cmd_sequencer_if bus ();

`ifdef VDP1_CMD_WATCHDOG_EN
  localparam logic [15:0] MaxCmds = 16'd3;
`else
  localparam logic [15:0] MaxCmds = 16'd16383;
`endif

  vdp1_cmd_sequencer #(
    .CALL_DEPTH (1),
    .MAX_CMDS   (MaxCmds)
  ) u_dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE       (CE),
    .START    (START),
    .bus      (bus),
    .COPR     (COPR),
    .LOPR     (LOPR),
    .CEF      (CEF),
    .BUSY     (BUSY),
    .WDOG_OVF (WDOG_OVF)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0]  mem [2048];
  logic [17:0]  exp_addr_q [$];
  logic [255:0] exp_cmd_q  [$];
  bit           ce_rand = 1'b0;
  int           lat_cnt = 0;
  logic         rd_prev = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
  endtask

  task automatic wr_table(input logic [15:0] ta, input logic [15:0] w0, input logic [15:0] w1);
    logic [17:0] a;
    for (int i = 0; i < 15; i++) begin
      a = {ta, 2'b00} + 18'(i);
      mem[a[10:0]] = (i == 0) ? w0 : (i == 1) ? w1 : {ta[7:0], 8'(i * 17)};
    end
  endtask

  function automatic logic [255:0] build_cmd(input logic [15:0] ta);
    logic [255:0] c;
    logic [17:0]  a;
    c = '0;
    for (int i = 0; i < 15; i++) begin
      a = {ta, 2'b00} + 18'(i);
      c[255 - 16*i -: 16] = mem[a[10:0]];
    end
    return c;
  endfunction

  task automatic push_reads(input logic [15:0] ta, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back({ta, 2'b00} + 18'(i));
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (BUSY !== 1'b0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 256'(BUSY), 256'(0));
    repeat (3) @(negedge CLK);
  endtask

  task automatic chk_end(input string name, input logic [15:0] lopr, input logic [15:0] copr);
    chk({name, "_cef"},   256'(CEF),  256'(1));
    chk({name, "_lopr"},  256'(LOPR), 256'(lopr));
    chk({name, "_copr"},  256'(COPR), 256'(copr));
    chk({name, "_reads_left"}, 256'(exp_addr_q.size()), 256'(0));
    chk({name, "_cmds_left"},  256'(exp_cmd_q.size()),  256'(0));
  endtask

  // VRAM arbiter model: one-cycle wait, RDY held while RD stays high.
  initial begin
    bus.VRAM_RDY = 1'b0;
    bus.VRAM_D   = 16'h0000;
    forever begin
      @(posedge CLK); #1;
      if (bus.VRAM_RD) begin
        if (lat_cnt >= 1) begin
          bus.VRAM_RDY = 1'b1;
          bus.VRAM_D   = mem[bus.VRAM_A[10:0]];
        end else begin
          lat_cnt++;
        end
      end else begin
        bus.VRAM_RDY = 1'b0;
        lat_cnt      = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK); #1;
      CE = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (RST_N && bus.VRAM_RD && !rd_prev) begin
      if (exp_addr_q.size() == 0) begin
        n_total++;
        $display("FAIL read_unexpected: got addr %0h, no read expected", bus.VRAM_A);
      end else begin
        chk("read_addr", 256'(bus.VRAM_A), 256'(exp_addr_q.pop_front()));
      end
    end
    rd_prev <= bus.VRAM_RD;
  end

  always @(negedge CLK) begin
    if (RST_N && CE && !START && bus.CMD_VALID && bus.CMD_READY) begin
      if (exp_cmd_q.size() == 0) begin
        n_total++;
        $display("FAIL cmd_unexpected: got cmd word0 %0h, no command expected", bus.CMD[255:240]);
      end else begin
        chk("cmd_issue", bus.CMD, exp_cmd_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit hold_ok;
    int n;
    bus.CMD_READY = 1'b1;
    clear_mem();

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_vram_rd",   256'(bus.VRAM_RD),   256'(0));
    chk("rst_vram_a",    256'(bus.VRAM_A),    256'(0));
    chk("rst_cmd_valid", 256'(bus.CMD_VALID), 256'(0));
    chk("rst_cmd",       bus.CMD,             256'(0));
    chk("rst_status",    256'({COPR, LOPR, CEF, BUSY, WDOG_OVF}), 256'(0));
    @(posedge CLK); #1 RST_N = 1'b1;

    // Linear list with random clock-enable gaps
    clear_mem();
    wr_table(16'h0000, 16'h0000, 16'h1111);
    wr_table(16'h0004, 16'h8000, 16'h0000);
    push_reads(16'h0000, 15);
    push_reads(16'h0004, 1);
    exp_cmd_q.push_back(build_cmd(16'h0000));
    pulse_start();
    ce_rand = 1'b1;
    wait_done("lin_done");
    ce_rand = 1'b0;
    chk_end("lin", 16'h0000, 16'h0004);
    chk("lin_wdog", 256'(WDOG_OVF), 256'(0));

    // Call / return
    clear_mem();
    wr_table(16'h0000, 16'h2000, 16'h0040);
    wr_table(16'h0040, 16'h3000, 16'h7777);
    wr_table(16'h0004, 16'h8000, 16'h0000);
    push_reads(16'h0000, 15);
    push_reads(16'h0040, 15);
    push_reads(16'h0004, 1);
    exp_cmd_q.push_back(build_cmd(16'h0000));
    exp_cmd_q.push_back(build_cmd(16'h0040));
    pulse_start();
    wait_done("call_done");
    chk_end("call", 16'h0040, 16'h0004);

    // Skip + jump
    clear_mem();
    wr_table(16'h0000, 16'h5000, 16'h0123);
    wr_table(16'h0120, 16'h8000, 16'h0000);
    push_reads(16'h0000, 2);
    push_reads(16'h0120, 1);
    pulse_start();
    wait_done("skip_done");
    chk_end("skip", 16'h0000, 16'h0120);

    // Return with empty stack, jump target masked to table alignment
    clear_mem();
    wr_table(16'h0000, 16'h1000, 16'h0013);
    wr_table(16'h0010, 16'h3000, 16'h0000);
    wr_table(16'h0014, 16'h8000, 16'h0000);
    push_reads(16'h0000, 15);
    push_reads(16'h0010, 15);
    push_reads(16'h0014, 1);
    exp_cmd_q.push_back(build_cmd(16'h0000));
    exp_cmd_q.push_back(build_cmd(16'h0010));
    pulse_start();
    wait_done("ret_done");
    chk_end("ret", 16'h0010, 16'h0014);

    // Backpressure, then restart coinciding with CMD_READY
    clear_mem();
    wr_table(16'h0000, 16'h0000, 16'h2222);
    wr_table(16'h0004, 16'h8000, 16'h0000);
    bus.CMD_READY = 1'b0;
    push_reads(16'h0000, 15);
    pulse_start();
    n = 0;
    while (bus.CMD_VALID !== 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("bp_valid_seen", 256'(bus.CMD_VALID), 256'(1));
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.CMD_VALID !== 1'b1 || bus.CMD !== build_cmd(16'h0000)) hold_ok = 1'b0;
    end
    chk("bp_hold", 256'(hold_ok), 256'(1));
    push_reads(16'h0000, 15);
    push_reads(16'h0004, 1);
    exp_cmd_q.push_back(build_cmd(16'h0000));
    @(posedge CLK); #1;
    START = 1'b1;
    bus.CMD_READY = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    @(negedge CLK);
    chk("rs_cmd_valid", 256'(bus.CMD_VALID), 256'(0));
    chk("rs_cef",       256'(CEF),           256'(0));
    chk("rs_lopr_kept", 256'(LOPR),          256'(16'h0010));
    chk("rs_busy",      256'(BUSY),          256'(1));
    wait_done("rs_done");
    chk_end("rs", 16'h0000, 16'h0004);

`ifdef VDP1_CMD_WATCHDOG_EN
    // Self-looping list stopped by the watchdog
    clear_mem();
    wr_table(16'h0000, 16'h1000, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      push_reads(16'h0000, 15);
      exp_cmd_q.push_back(build_cmd(16'h0000));
    end
    pulse_start();
    wait_done("wd_done");
    chk_end("wd", 16'h0000, 16'h0000);
    chk("wd_ovf", 256'(WDOG_OVF), 256'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
